spi_xfer_sched: RTL and testbench

Transfer scheduler that shares the SPI controller's master-mode datapath among NREQ on-chip requesters. It arbitrates round-robin and programs the controller's SFR write port (CR1, BR, CR2, DR1). It then polls the status register for master completion, reads back the received byte and returns it to the winning requester with a one-cycle acknowledge. It sits between the requester logic and the SFR interface of the SPI master/slave controller, and drives that controller's slave-select input.

---
 rtl/spi_xfer_sched.sv | 204 ++++++++++++++++++++
 tb/tb_spi_xfer_sched.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_xfer_sched.sv
// Round-robin scheduler sharing the SPI master datapath among NREQ requesters.
// Programs CR1/BR/CR2/DR1 through the SFR port, polls SR for completion, returns DR2.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// S_IDLE      | no transfer; wait for any request
// S_ARB       | pick next requester round-robin, latch id/tx, drive slave select
// S_WR_CR1    | write CR1 (master bit forced), skipped on cache hit
// S_WR_BR     | write BR, skipped on cache hit
// S_WR_CR2    | write CR2 = 0x01, only on first transfer after reset
// S_WR_DR     | write tx byte to DR1, launches the transfer
// S_WAIT_DONE | poll SR[0] until set or timeout
// S_RD_DR2    | capture received byte from DR2
// S_RESP      | one-cycle ack to the granted requester
// S_DRAIN     | wait for SR[0] to clear, then release slave select
module spi_xfer_sched #(
   parameter int NREQ = 4,
   parameter int TO_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req,
   input  logic [3*NREQ-1:0] req_sel,
   input  logic [8*NREQ-1:0] req_tx,
   input  logic [7:0]        cfg_cr1,
   input  logic [7:0]        cfg_br,
   output logic [NREQ-1:0]   ack,
   output logic [7:0]        rx_data,
   output logic              err,
   output logic              busy,
   output logic [2:0]        gnt_id,
   output logic              sfrwe,
   output logic [2:0]        sfraddr_w,
   output logic [2:0]        sfraddr_r,
   output logic [7:0]        spidata_o,
   input  logic [7:0]        sfrdata_i,
   output logic [7:0]        spssn
);

   typedef enum logic [3:0] {
      S_IDLE, S_ARB, S_WR_CR1, S_WR_BR, S_WR_CR2,
      S_WR_DR, S_WAIT_DONE, S_RD_DR2, S_RESP, S_DRAIN
   } state_t;

   state_t            state_q, state_d;
   logic [2:0]        ptr_q;
   logic [2:0]        id_q;
   logic [7:0]        tx_q;
   logic [7:0]        spssn_q;
   logic [7:0]        rx_q;
   logic              err_q;
   logic              cache_vld_q;
   logic [7:0]        cr1_q;
   logic [7:0]        br_q;
   logic              cr2_done_q;
   logic [TO_W-1:0]   tmr_q;

   logic              arb_hit;
   logic [2:0]        arb_id;
   logic [2:0]        arb_sel;
   logic [7:0]        arb_tx;
   int                best_d;
   logic [7:0]        cr1_eff;
   logic              need_cr1, need_br, need_cr2;
   logic              sr_done;
   logic              tmr_tc;

   assign cr1_eff  = cfg_cr1 | 8'h10;
   assign need_cr1 = !(cache_vld_q && (cr1_eff == cr1_q));
   assign need_br  = !(cache_vld_q && (cfg_br == br_q));
   assign need_cr2 = !cr2_done_q;
   assign sr_done  = sfrdata_i[0];
   assign tmr_tc   = (tmr_q == TO_W'(1));

   // Smallest circular distance from the slot after the last grant wins.
   always_comb begin
      arb_hit = 1'b0;
      arb_id  = 3'd0;
      arb_sel = 3'd0;
      arb_tx  = 8'h00;
      best_d  = NREQ;
      for (int i = 0; i < NREQ; i++) begin
         if (req[i] && (((i + NREQ - 1 - int'(ptr_q)) % NREQ) < best_d)) begin
            best_d  = (i + NREQ - 1 - int'(ptr_q)) % NREQ;
            arb_hit = 1'b1;
            arb_id  = 3'(i);
            arb_sel = req_sel[3*i +: 3];
            arb_tx  = req_tx[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:      if (|req) state_d = S_ARB;
         S_ARB: begin
            if (!arb_hit)     state_d = S_IDLE;
            else if (need_cr1) state_d = S_WR_CR1;
            else if (need_br)  state_d = S_WR_BR;
            else if (need_cr2) state_d = S_WR_CR2;
            else               state_d = S_WR_DR;
         end
         S_WR_CR1: begin
            if (need_br)       state_d = S_WR_BR;
            else if (need_cr2) state_d = S_WR_CR2;
            else               state_d = S_WR_DR;
         end
         S_WR_BR:     state_d = need_cr2 ? S_WR_CR2 : S_WR_DR;
         S_WR_CR2:    state_d = S_WR_DR;
         S_WR_DR:     state_d = S_WAIT_DONE;
         S_WAIT_DONE: begin
            if (sr_done)     state_d = S_RD_DR2;
            else if (tmr_tc) state_d = S_RESP;
         end
         S_RD_DR2:    state_d = S_RESP;
         S_RESP:      state_d = S_DRAIN;
         S_DRAIN:     if (!sr_done || tmr_tc) state_d = S_IDLE;
         default:     state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q       <= 3'(NREQ - 1);
         id_q        <= 3'd0;
         tx_q        <= 8'h00;
         spssn_q     <= 8'hFF;
         rx_q        <= 8'h00;
         err_q       <= 1'b0;
         cache_vld_q <= 1'b0;
         cr1_q       <= 8'h00;
         br_q        <= 8'h00;
         cr2_done_q  <= 1'b0;
         tmr_q       <= '0;
      end else begin
         case (state_q)
            S_ARB: begin
               if (arb_hit) begin
                  id_q    <= arb_id;
                  tx_q    <= arb_tx;
                  spssn_q <= ~(8'd1 << arb_sel);
               end
            end
            S_WR_CR1: cr1_q <= cr1_eff;
            S_WR_BR:  br_q  <= cfg_br;
            S_WR_CR2: cr2_done_q <= 1'b1;
            S_WR_DR: begin
               cache_vld_q <= 1'b1;
               tmr_q       <= '1;
            end
            S_WAIT_DONE: begin
               tmr_q <= tmr_q - TO_W'(1);
               // A timed-out controller may hold stale config, so force a full rewrite next time.
               if (!sr_done && tmr_tc) begin
                  err_q       <= 1'b1;
                  rx_q        <= 8'h00;
                  cache_vld_q <= 1'b0;
               end
            end
            S_RD_DR2: rx_q <= sfrdata_i;
            S_RESP: begin
               err_q <= 1'b0;
               ptr_q <= id_q;
               tmr_q <= '1;
            end
            S_DRAIN: begin
               tmr_q <= tmr_q - TO_W'(1);
               if (!sr_done || tmr_tc) spssn_q <= 8'hFF;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      sfrwe     = 1'b0;
      sfraddr_w = 3'd0;
      sfraddr_r = 3'd3;
      spidata_o = 8'h00;
      ack       = '0;
      case (state_q)
         S_WR_CR1: begin sfrwe = 1'b1; sfraddr_w = 3'd0; spidata_o = cr1_eff; end
         S_WR_BR:  begin sfrwe = 1'b1; sfraddr_w = 3'd2; spidata_o = cfg_br;  end
         S_WR_CR2: begin sfrwe = 1'b1; sfraddr_w = 3'd1; spidata_o = 8'h01;   end
         S_WR_DR:  begin sfrwe = 1'b1; sfraddr_w = 3'd3; spidata_o = tx_q;    end
         S_RD_DR2: sfraddr_r = 3'd5;
         S_RESP:   ack = NREQ'(1) << id_q;
         default: ;
      endcase
   end

   assign busy    = (state_q != S_IDLE);
   assign gnt_id  = id_q;
   assign rx_data = rx_q;
   assign err     = err_q;
   assign spssn   = spssn_q;

endmodule

// File: tb/tb_spi_xfer_sched.sv
// Bench for spi_xfer_sched: loopback SFR model (DR2 = DR1 ^ 0x99) plus a
// transaction-level scoreboard of arbitration, config writes and ack timing.
module tb_spi_xfer_sched;
   localparam int NREQ = 4;
   localparam int TO_W = 16;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [NREQ-1:0]   req = '0;
   logic [3*NREQ-1:0] req_sel = '0;
   logic [8*NREQ-1:0] req_tx = '0;
   logic [7:0]        cfg_cr1 = 8'h23;
   logic [7:0]        cfg_br = 8'h04;
   logic [NREQ-1:0]   ack;
   logic [7:0]        rx_data;
   logic              err;
   logic              busy;
   logic [2:0]        gnt_id;
   logic              sfrwe;
   logic [2:0]        sfraddr_w;
   logic [2:0]        sfraddr_r;
   logic [7:0]        spidata_o;
   logic [7:0]        sfrdata_i;
   logic [7:0]        spssn;

   spi_xfer_sched #(.NREQ(NREQ), .TO_W(TO_W)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .req_sel(req_sel), .req_tx(req_tx),
      .cfg_cr1(cfg_cr1), .cfg_br(cfg_br), .ack(ack), .rx_data(rx_data), .err(err),
      .busy(busy), .gnt_id(gnt_id), .sfrwe(sfrwe), .sfraddr_w(sfraddr_w),
      .sfraddr_r(sfraddr_r), .spidata_o(spidata_o), .sfrdata_i(sfrdata_i), .spssn(spssn)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
      end
   endtask

   // SFR model: SR[0] rises dly cycles after the DR1 write, clears once DR2 is read.
   int         dly = 8;
   bit         never_done = 1'b0;
   int         sr_hi_at = 0;
   bit         sr_clr = 1'b1;
   logic       sr0_r = 1'b0;
   logic [7:0] dr2_r = 8'h00;
   assign sfrdata_i = (sfraddr_r == 3'd5) ? dr2_r :
                      (sfraddr_r == 3'd3) ? {7'd0, sr0_r} : 8'h00;

   typedef struct { logic [2:0] a; logic [7:0] d; } wr_t;
   wr_t        wq[$];
   int         m_ptr = NREQ - 1;
   bit         m_valid = 1'b0;
   bit         m_cr2 = 1'b0;
   logic [7:0] m_cr1 = 8'h00, m_br = 8'h00;
   bit         pending = 1'b0;
   int         win = 0;
   logic [7:0] exp_ss = 8'hFF, exp_rx = 8'h00;
   bit         exp_err = 1'b0;
   int         exp_ack_cyc = -1;
   bit         prev_busy = 1'b0;
   int         req_cyc = 0;
   int         n_ack = 0;
   int         last_lat = 0, last_nwr = 0, cur_nwr = 0;
   int         first_addr = 0;
   logic [7:0] last_ss = 8'h00, last_rx = 8'h00;
   logic       last_err = 1'b0;
   int         gnt_seq[16];

   always @(negedge clk) begin
      if (!rst_n) begin
         wq.delete();
         m_ptr = NREQ - 1; m_valid = 0; m_cr2 = 0;
         pending = 0; prev_busy = 0; sr_clr = 1; sr0_r = 0; exp_ack_cyc = -1;
      end else begin
         if (sfrwe && sfraddr_w == 3'd3) begin
            dr2_r = spidata_o ^ 8'h99;
            sr_clr = 0;
            sr_hi_at = cyc + dly;
            exp_err = never_done;
            exp_ack_cyc = never_done ? cyc + (1 << TO_W) : cyc + dly + 2;
         end
         if (sfraddr_r == 3'd5) sr_clr = 1;
         sr0_r = !never_done && !sr_clr && (cyc >= sr_hi_at);

         if (busy && !prev_busy) begin
            win = -1;
            for (int k = 1; k <= NREQ; k++)
               if (win < 0 && req[(m_ptr + k) % NREQ]) win = (m_ptr + k) % NREQ;
            if (win < 0) begin
               chk("arb_no_request", 32'(req), 32'hFFFF_FFFF);
               win = 0;
            end
            exp_ss = ~(8'd1 << req_sel[3*win +: 3]);
            exp_rx = req_tx[8*win +: 8] ^ 8'h99;
            if (!(m_valid && (cfg_cr1 | 8'h10) == m_cr1)) wq.push_back('{3'd0, cfg_cr1 | 8'h10});
            if (!(m_valid && cfg_br == m_br))             wq.push_back('{3'd2, cfg_br});
            if (!m_cr2)                                   wq.push_back('{3'd1, 8'h01});
            wq.push_back('{3'd3, req_tx[8*win +: 8]});
            m_cr1 = cfg_cr1 | 8'h10; m_br = cfg_br; m_valid = 1; m_cr2 = 1;
            pending = 1; exp_ack_cyc = -1; cur_nwr = 0;
            chk("spssn_in_arb", 32'(spssn), 32'hFF);
         end else if (busy) begin
            chk("spssn_active", 32'(spssn), 32'(exp_ss));
            if (prev_busy && cur_nwr == 0 && !sfrwe) last_ss = spssn;
            if (cur_nwr == 0) last_ss = spssn;
         end else begin
            chk("spssn_idle", 32'(spssn), 32'hFF);
         end

         if (sfrwe) begin
            if (wq.size() == 0) chk("unexpected_sfr_write", 32'(sfraddr_w), 32'hFFFF_FFFF);
            else begin
               if (cur_nwr == 0) first_addr = int'(sfraddr_w);
               chk("sfr_wr_addr", 32'(sfraddr_w), 32'(wq[0].a));
               chk("sfr_wr_data", 32'(spidata_o), 32'(wq[0].d));
               void'(wq.pop_front());
            end
            cur_nwr++;
         end

         if (pending && cyc == exp_ack_cyc) begin
            chk("ack_vector", 32'(ack), 32'(NREQ'(1) << win));
            chk("gnt_id", 32'(gnt_id), 32'(win));
            chk("rx_data", 32'(rx_data), exp_err ? 32'h0 : 32'(exp_rx));
            chk("err", 32'(err), 32'(exp_err));
            chk("busy_in_ack", 32'(busy), 32'h1);
            chk("writes_outstanding", 32'(wq.size()), 32'h0);
            last_lat = cyc - req_cyc; last_nwr = cur_nwr;
            last_rx = rx_data; last_err = err;
            if (n_ack < 16) gnt_seq[n_ack] = int'(gnt_id);
            m_ptr = win;
            if (exp_err) m_valid = 0;
            pending = 0;
            n_ack++;
         end else if (ack != '0) begin
            chk("unexpected_ack", 32'(ack), 32'h0);
         end
         prev_busy = busy;
      end
   end

   task automatic do_req(input int id, input logic [2:0] sel, input logic [7:0] tx);
      @(posedge clk); #1;
      req_sel[3*id +: 3] = sel;
      req_tx[8*id +: 8]  = tx;
      req[id] = 1'b1;
      req_cyc = cyc;
   endtask

   task automatic wait_acks(input int n, input int budget);
      int start, t;
      start = n_ack; t = 0;
      while (n_ack < start + n && t < budget) begin
         @(negedge clk); #1; t++;
      end
      if (n_ack < start + n) begin
         n_chk++; n_err++;
         $display("FAIL ack_timeout: got %0d acks expected %0d", n_ack - start, n);
      end
   endtask

   task automatic drop_and_idle();
      int t;
      @(posedge clk); #1; req = '0;
      t = 0;
      while (busy && t < 200) begin @(negedge clk); #1; t++; end
      chk("return_to_idle", 32'(busy), 32'h0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int acks_before;
      repeat (3) @(posedge clk); #1;
      chk("rst_sfrwe", 32'(sfrwe), 0);       chk("rst_sfraddr_w", 32'(sfraddr_w), 0);
      chk("rst_sfraddr_r", 32'(sfraddr_r), 3); chk("rst_spidata", 32'(spidata_o), 0);
      chk("rst_spssn", 32'(spssn), 32'hFF);  chk("rst_ack", 32'(ack), 0);
      chk("rst_rx", 32'(rx_data), 0);        chk("rst_err", 32'(err), 0);
      chk("rst_busy", 32'(busy), 0);         chk("rst_gnt", 32'(gnt_id), 0);
      rst_n = 1'b1;

      // first transfer: full programming
      do_req(0, 3'd2, 8'hA5); wait_acks(1, 100);
      chk("t1_latency", last_lat, 15); chk("t1_nwr", last_nwr, 4);
      chk("t1_spssn", 32'(last_ss), 32'hFB); chk("t1_rx", 32'(last_rx), 32'h3C);
      chk("t1_err", 32'(last_err), 0);
      drop_and_idle();

      // cache hit
      do_req(0, 3'd2, 8'h5A); wait_acks(1, 100);
      chk("t2_latency", last_lat, 12); chk("t2_nwr", last_nwr, 1);
      chk("t2_rx", 32'(last_rx), 32'hC3);
      drop_and_idle();

      // BR changed only
      cfg_br = 8'h07;
      do_req(3, 3'd5, 8'h11); wait_acks(1, 100);
      chk("t3_latency", last_lat, 13); chk("t3_nwr", last_nwr, 2);
      chk("t3_first_addr", first_addr, 2); chk("t3_spssn", 32'(last_ss), 32'hDF);
      drop_and_idle();

      // all four continuously requesting
      @(posedge clk); #1;
      req_sel = {3'd7, 3'd6, 3'd1, 3'd0};
      req_tx  = {8'h44, 8'h33, 8'h22, 8'h11};
      acks_before = n_ack;
      req = 4'hF;
      wait_acks(5, 400);
      chk("rr_g0", gnt_seq[acks_before],     0); chk("rr_g1", gnt_seq[acks_before + 1], 1);
      chk("rr_g2", gnt_seq[acks_before + 2], 2); chk("rr_g3", gnt_seq[acks_before + 3], 3);
      chk("rr_g4", gnt_seq[acks_before + 4], 0);
      drop_and_idle();

      // completion timeout
      never_done = 1'b1;
      do_req(1, 3'd3, 8'h77); wait_acks(1, 70000);
      chk("to_latency", last_lat, 2 + 65536); chk("to_err", 32'(last_err), 1);
      chk("to_rx", 32'(last_rx), 0);
      drop_and_idle();
      never_done = 1'b0;

      // after timeout CR1 and BR rewritten, CR2 not
      do_req(2, 3'd4, 8'h81); wait_acks(1, 100);
      chk("post_to_nwr", last_nwr, 3); chk("post_to_latency", last_lat, 14);
      drop_and_idle();

      // reset during WAIT_DONE
      never_done = 1'b1;
      acks_before = n_ack;
      do_req(0, 3'd1, 8'h3E);
      repeat (8) @(posedge clk); #1;
      chk("pre_reset_busy", 32'(busy), 1);
      rst_n = 1'b0; req = '0;
      #1;
      chk("mid_rst_spssn", 32'(spssn), 32'hFF); chk("mid_rst_busy", 32'(busy), 0);
      chk("mid_rst_ack", 32'(ack), 0);          chk("mid_rst_sfrwe", 32'(sfrwe), 0);
      repeat (3) @(posedge clk); #1;
      never_done = 1'b0;
      rst_n = 1'b1;
      repeat (2) @(posedge clk); #1;
      chk("no_ack_after_reset", n_ack - acks_before, 0);
      do_req(1, 3'd0, 8'h96); wait_acks(1, 100);
      chk("post_rst_nwr", last_nwr, 4); chk("post_rst_latency", last_lat, 15);
      chk("post_rst_rx", 32'(last_rx), 32'h0F);
      drop_and_idle();

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
